// File: rtl/multicycle_control.sv
// Multicycle RISC-V main controller FSM with ALU decoder.
// Control outputs are Moore on state; pc_write is Mealy on zero; imm_src/alu_control decode IR fields.
module multicycle_control #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // ALU decoder: ALUOp 00 add, 01 sub, 10 selects by funct3 (sub only for R-type with funct7b5).
  function automatic logic [2:0] alu_decode(
    input logic [1:0] alu_op,
    input logic       op_b5,
    input logic [2:0] f3,
    input logic       f7b5
  );
    logic [2:0] ctl;
    ctl = 3'b000;
    case (alu_op)
      2'b00: ctl = 3'b000;
      2'b01: ctl = 3'b001;
      2'b10: begin
        case (f3)
          3'b000:  ctl = (op_b5 & f7b5) ? 3'b001 : 3'b000;
          3'b010:  ctl = 3'b101;
          3'b110:  ctl = 3'b011;
          3'b111:  ctl = 3'b010;
          default: ctl = 3'b000;
        endcase
      end
      default: ctl = 3'b000;
    endcase
    return ctl;
  endfunction

  function automatic logic [1:0] imm_decode(input logic [6:0] opc);
    logic [1:0] fmt;
    case (opc)
      OP_SW:   fmt = 2'b01;
      OP_BEQ:  fmt = 2'b10;
      OP_JAL:  fmt = 2'b11;
      default: fmt = 2'b00;
    endcase
    return fmt;
  endfunction

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       illegal_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = S_FETCH;
    alu_op        = 2'b00;
    pc_update     = 1'b0;
    branch        = 1'b0;
    adr_src       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_update    = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        // PC+imm lands in ALUOut here so BEQ can use it as the branch target.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            illegal_raw = 1'b1;
            state_d     = ILLEGAL_HALT ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Write enables are held low during reset so an aborted instruction commits nothing.
  assign pc_write    = ~rst & (pc_update | (branch & zero));
  assign mem_write   = ~rst & mem_write_raw;
  assign ir_write    = ~rst & ir_write_raw;
  assign reg_write   = ~rst & reg_write_raw;
  assign illegal     = ~rst & illegal_raw;
  assign imm_src     = imm_decode(op);
  assign alu_control = alu_decode(alu_op, op[5], funct3, funct7b5);
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction walks, randomized instruction stream,
// mid-instruction reset and the illegal-opcode halt variant.
module tb_multicycle_control;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BEQ = 7'b1100011;

  typedef int iq_t[$];

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       illegal;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst, rst_h;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero;

  logic       m_pc_write, m_adr_src, m_mem_write, m_ir_write, m_reg_write, m_illegal;
  logic [1:0] m_result_src, m_alu_src_a, m_alu_src_b, m_imm_src;
  logic [2:0] m_alu_control;
  logic [3:0] m_state;
  logic       h_pc_write, h_adr_src, h_mem_write, h_ir_write, h_reg_write, h_illegal;
  logic [1:0] h_result_src, h_alu_src_a, h_alu_src_b, h_imm_src;
  logic [2:0] h_alu_control;
  logic [3:0] h_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control #(.ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(m_pc_write), .adr_src(m_adr_src), .mem_write(m_mem_write),
    .ir_write(m_ir_write), .reg_write(m_reg_write), .result_src(m_result_src),
    .alu_src_a(m_alu_src_a), .alu_src_b(m_alu_src_b), .imm_src(m_imm_src),
    .alu_control(m_alu_control), .illegal(m_illegal), .state(m_state)
  );

  multicycle_control #(.ILLEGAL_HALT(1'b1)) dut_halt (
    .clk(clk), .rst(rst_h), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(h_pc_write), .adr_src(h_adr_src), .mem_write(h_mem_write),
    .ir_write(h_ir_write), .reg_write(h_reg_write), .result_src(h_result_src),
    .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b), .imm_src(h_imm_src),
    .alu_control(h_alu_control), .illegal(h_illegal), .state(h_state)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t get_obs(input bit h);
    ctl_t o;
    if (h) o = '{h_state, h_pc_write, h_adr_src, h_mem_write, h_ir_write, h_reg_write,
                 h_result_src, h_alu_src_a, h_alu_src_b, h_imm_src, h_alu_control, h_illegal};
    else   o = '{m_state, m_pc_write, m_adr_src, m_mem_write, m_ir_write, m_reg_write,
                 m_result_src, m_alu_src_a, m_alu_src_b, m_imm_src, m_alu_control, m_illegal};
    return o;
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == JAL) || (o == BEQ);
  endfunction

  // Expected state walk of one instruction, straight from the latency rules.
  function automatic iq_t seq_for(input logic [6:0] o);
    iq_t q;
    case (o)
      LW:      q = '{0, 1, 2, 3, 4};
      SW:      q = '{0, 1, 2, 5};
      RT:      q = '{0, 1, 6, 7};
      IT:      q = '{0, 1, 8, 7};
      JAL:     q = '{0, 1, 9, 7};
      BEQ:     q = '{0, 1, 10};
      default: q = '{0, 1};
    endcase
    return q;
  endfunction

  // Per-state control table plus IR-field decoding, as a reference.
  function automatic ctl_t model(input int s, input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z, input logic r);
    ctl_t e;
    logic pcu, br;
    int   aop;
    e = '0; pcu = 1'b0; br = 1'b0; aop = 0;
    e.state = 4'(s);
    case (s)
      0:  begin e.ir_write = 1; e.alu_src_b = 2; e.result_src = 2; pcu = 1; end
      1:  begin e.alu_src_a = 1; e.alu_src_b = 1; e.illegal = !is_legal(o); end
      2:  begin e.alu_src_a = 2; e.alu_src_b = 1; end
      3:  begin e.adr_src = 1; end
      4:  begin e.result_src = 1; e.reg_write = 1; end
      5:  begin e.adr_src = 1; e.mem_write = 1; end
      6:  begin e.alu_src_a = 2; aop = 2; end
      7:  begin e.reg_write = 1; end
      8:  begin e.alu_src_a = 2; e.alu_src_b = 1; aop = 2; end
      9:  begin e.alu_src_a = 1; e.alu_src_b = 2; pcu = 1; end
      10: begin e.alu_src_a = 2; aop = 1; br = 1; end
      default: ;
    endcase
    e.pc_write = pcu | (br & z);
    e.imm_src = (o == SW) ? 2'd1 : (o == BEQ) ? 2'd2 : (o == JAL) ? 2'd3 : 2'd0;
    if (aop == 0)      e.alu_control = 3'b000;
    else if (aop == 1) e.alu_control = 3'b001;
    else if (f3 == 3'b000) e.alu_control = (o[5] && f7) ? 3'b001 : 3'b000;
    else if (f3 == 3'b010) e.alu_control = 3'b101;
    else if (f3 == 3'b110) e.alu_control = 3'b011;
    else if (f3 == 3'b111) e.alu_control = 3'b010;
    else                   e.alu_control = 3'b000;
    if (r) begin
      e.pc_write = 0; e.ir_write = 0; e.mem_write = 0; e.reg_write = 0; e.illegal = 0;
    end
    return e;
  endfunction

  task automatic check_now(input bit h, input int s, input string ctx);
    ctl_t o, e;
    logic r;
    r = h ? rst_h : rst;
    o = get_obs(h);
    e = model(s, op, funct3, funct7b5, zero, r);
    chk($sformatf("%s.s%0d.state", ctx, s), 8'(o.state), 8'(e.state));
    chk($sformatf("%s.s%0d.pc_write", ctx, s), 8'(o.pc_write), 8'(e.pc_write));
    chk($sformatf("%s.s%0d.mem_write", ctx, s), 8'(o.mem_write), 8'(e.mem_write));
    chk($sformatf("%s.s%0d.ir_write", ctx, s), 8'(o.ir_write), 8'(e.ir_write));
    chk($sformatf("%s.s%0d.reg_write", ctx, s), 8'(o.reg_write), 8'(e.reg_write));
    chk($sformatf("%s.s%0d.illegal", ctx, s), 8'(o.illegal), 8'(e.illegal));
    if (!r) begin
      chk($sformatf("%s.s%0d.adr_src", ctx, s), 8'(o.adr_src), 8'(e.adr_src));
      chk($sformatf("%s.s%0d.result_src", ctx, s), 8'(o.result_src), 8'(e.result_src));
      chk($sformatf("%s.s%0d.alu_src_a", ctx, s), 8'(o.alu_src_a), 8'(e.alu_src_a));
      chk($sformatf("%s.s%0d.alu_src_b", ctx, s), 8'(o.alu_src_b), 8'(e.alu_src_b));
      chk($sformatf("%s.s%0d.imm_src", ctx, s), 8'(o.imm_src), 8'(e.imm_src));
      chk($sformatf("%s.s%0d.alu_control", ctx, s), 8'(o.alu_control), 8'(e.alu_control));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // zmode < 0 randomizes zero every cycle, otherwise holds it at zmode.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int zmode, input string ctx);
    iq_t q;
    op = o; funct3 = f3; funct7b5 = f7;
    q = seq_for(o);
    foreach (q[i]) begin
      zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
      @(negedge clk);
      check_now(1'b0, q[i], ctx);
      step();
    end
  endtask

  initial begin
    logic [6:0] ro;
    rst = 1'b1; rst_h = 1'b1;
    op = 7'($urandom); funct3 = 3'($urandom); funct7b5 = 1'b1; zero = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check_now(1'b0, 0, "reset");
    check_now(1'b1, 0, "reset_h");
    step();
    rst = 1'b0;

    run_instr(LW, 3'b010, 1'b0, -1, "lw");
    run_instr(SW, 3'b010, 1'b0, -1, "sw");
    run_instr(RT, 3'b000, 1'b1, -1, "sub");
    run_instr(IT, 3'b000, 1'b1, -1, "addi");
    run_instr(RT, 3'b010, 1'b0, -1, "slt");
    run_instr(RT, 3'b110, 1'b0, -1, "or");
    run_instr(IT, 3'b111, 1'b0, -1, "andi");
    run_instr(BEQ, 3'b000, 1'b0, 1, "beq_taken");
    run_instr(BEQ, 3'b000, 1'b0, 0, "beq_not");
    run_instr(JAL, 3'b101, 1'b1, -1, "jal");
    run_instr(7'b0000000, 3'b000, 1'b0, -1, "illegal");
    run_instr(LW, 3'b010, 1'b0, -1, "after_illegal");

    // Reset arriving in MEMWRITE must suppress the store.
    op = SW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_now(1'b0, i, "sw_abort");
      step();
    end
    rst = 1'b1;
    @(negedge clk);
    check_now(1'b0, 5, "rst_in_memwrite");
    step();
    @(negedge clk);
    check_now(1'b0, 0, "rst_held");
    step();
    rst = 1'b0;
    @(negedge clk);
    check_now(1'b0, 0, "resume_fetch");
    step();
    @(negedge clk);
    check_now(1'b0, 1, "resume_decode");
    step();
    @(negedge clk);
    check_now(1'b0, 2, "resume_memadr");
    step();
    @(negedge clk);
    check_now(1'b0, 5, "resume_memwrite");
    step();

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0: ro = LW;
        1: ro = SW;
        2: ro = RT;
        3: ro = IT;
        4: ro = JAL;
        5: ro = BEQ;
        default: ro = 7'($urandom);
      endcase
      run_instr(ro, 3'($urandom), 1'($urandom), -1, $sformatf("rnd%0d", n));
    end

    // Halting variant: unknown opcode parks the FSM until reset.
    rst = 1'b1;
    op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0;
    step();
    rst_h = 1'b0;
    @(negedge clk);
    check_now(1'b1, 0, "halt_fetch");
    step();
    @(negedge clk);
    check_now(1'b1, 1, "halt_decode");
    step();
    for (int i = 0; i < 20; i++) begin
      zero = 1'($urandom);
      @(negedge clk);
      check_now(1'b1, 11, $sformatf("halt%0d", i));
      step();
    end
    rst_h = 1'b1;
    @(negedge clk);
    check_now(1'b1, 11, "halt_rst");
    step();
    @(negedge clk);
    check_now(1'b1, 0, "halt_cleared");
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle RISC-V main controller FSM plus ALU decoder.
- Drives the alu's 3-bit ALUControl and consumes its Zero flag, so it is the other end of that interface.
- Sequences fetch/decode/execute/memory/writeback for lw, sw, R-type, I-type ALU, beq and jal over one shared ALU and one unified memory.
- Sits in the datapath top beside alu, the register file, the instruction register (IR) and the PC register.

Parameters:
- ILLEGAL_HALT, default 0: when 1, an unknown opcode parks the FSM in HALT until reset. When 0, the FSM returns to FETCH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zero  in  1  ALU Zero flag
- pc_write  out  1  PC load enable
- adr_src  out  1  memory address mux: 0=PC, 1=ALUOut
- mem_write  out  1  memory write enable
- ir_write  out  1  IR/OldPC load enable
- reg_write  out  1  register file write enable
- result_src  out  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a  out  2  ALU A mux: 00=PC, 01=OldPC, 10=rs1
- alu_src_b  out  2  ALU B mux: 00=rs2, 01=ImmExt, 10=const 4
- imm_src  out  2  immediate format: 00=I, 01=S, 10=B, 11=J
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  out  1  one-cycle pulse in DECODE on an unknown opcode
- state  out  4  current state encoding, for debug and verification

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, HALT=11.
- Unlisted outputs are 0 in each state. ALUOp defaults to 00.
- FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, ALUOp=00, result_src=10, PCUpdate=1. Next state DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - anything else -> illegal=1, then HALT if ILLEGAL_HALT else FETCH
- MEMADR: alu_src_a=10, alu_src_b=01, ALUOp=00. Next MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Next MEMWB.
- MEMWB: result_src=01, reg_write=1. Next FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1. Next FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, ALUOp=10. Next ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, ALUOp=10. Next ALUWB.
- ALUWB: result_src=00, reg_write=1. Next FETCH.
- JAL: alu_src_a=01, alu_src_b=10, ALUOp=00, result_src=00, PCUpdate=1. Next ALUWB.
- BEQ: alu_src_a=10, alu_src_b=00, ALUOp=01, result_src=00, Branch=1. Next FETCH.
- HALT: all enables 0. Stays in HALT until rst.
- pc_write = PCUpdate | (Branch & zero). It is combinational (Mealy) on zero, so zero only matters in BEQ.
- All other outputs are Moore on state, except imm_src and alu_control, which are combinational on op/funct3/funct7b5.
- imm_src:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - otherwise 00
- ALU decode:
  - ALUOp=00 -> 000
  - ALUOp=01 -> 001
  - ALUOp=10, funct3=000 -> 001 if (op[5] & funct7b5), else 000
  - ALUOp=10, funct3=010 -> 101
  - ALUOp=10, funct3=110 -> 011
  - ALUOp=10, funct3=111 -> 010
  - ALUOp=10, any other funct3 -> 000
- Latency: lw 5 cycles; sw, R, I and jal 4 cycles; beq 3 cycles; unknown opcode 2 cycles (when ILLEGAL_HALT=0).
- Reset: state<=FETCH on the clk edge with rst=1.
  - While rst=1, force pc_write, ir_write, mem_write, reg_write and illegal to 0. Other outputs are don't-care.
  - The first cycle after rst deasserts is FETCH.
  - rst mid-instruction aborts it with no further writes.
- No X on any output in any reachable state.

Test Plan:
- lw (op=0000011): states 0,1,2,3,4,0. reg_write=1 only in MEMWB with result_src=01. adr_src=1 in MEMREAD.
- sub (op=0110011, funct3=000, funct7b5=1): alu_control=001 in EXECR. addi with the same bits (op=0010011): alu_control=000. slt (funct3=010): 101.
- beq with zero=1: pc_write=1 in the BEQ cycle. With zero=0: pc_write=0. Both return to FETCH next cycle. alu_control=001.
- jal (op=1101111): states 0,1,9,7,0. pc_write=1 in JAL. imm_src=11. reg_write=1 in ALUWB.
- op=0000000 with ILLEGAL_HALT=0: illegal=1 for one cycle in DECODE, then FETCH. With ILLEGAL_HALT=1: state=11 held for 20 cycles until rst.
- rst asserted during MEMWRITE: mem_write=0 that cycle. state=0 after the edge. Fetch resumes one cycle after rst drops.
